// File: rtl/mic_pkg.sv
// mic_pkg: shared constants, types and helpers for the PDM microphone receiver
package mic_pkg;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } edge_sel_e;

    localparam logic signed [1:0] PDM_ONE  = 2'sb01;
    localparam logic signed [1:0] PDM_ZERO = 2'sb11;

    function automatic int cic_width(input int order, input int decim);
        return order * $clog2(decim) + 2;
    endfunction

endpackage

// File: rtl/mic_cic_decim.sv
// mic_cic_decim: CIC decimator turning per-bit strobes into truncated signed PCM results
module mic_cic_decim
    import mic_pkg::*;
#(
    parameter int DECIM     = 64,
    parameter int ORDER     = 3,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk_board,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 strobe,
    input  logic                 bit_in,
    output logic [OUT_WIDTH-1:0] result,
    output logic                 result_strobe
);

    localparam int CIC_W = cic_width(ORDER, DECIM);
    localparam int DW    = $clog2(DECIM);

    logic signed [1:0] x;
    logic [CIC_W-1:0]  x_ext;
    logic [CIC_W-1:0]  latched;
    logic [CIC_W-1:0]  y;
    logic [DW-1:0]     decim_cnt;
    logic              go;

    assign x     = bit_in ? PDM_ONE : PDM_ZERO;
    assign x_ext = {{(CIC_W - 2){x[1]}}, x};

    genvar g;
    for (g = 0; g < ORDER; g++) begin : stg
        logic [CIC_W-1:0] integ, integ_nxt, dly, comb_in, comb_out;
        if (g == 0) begin : first
            assign integ_nxt = integ + x_ext;
            assign comb_in   = latched;
        end else begin : rest
            assign integ_nxt = integ + stg[g-1].integ_nxt;
            assign comb_in   = stg[g-1].comb_out;
        end
        assign comb_out = comb_in - dly;
        // integrator advances per strobe; comb delay captures its input once per decimated result
        always_ff @(posedge clk_board or negedge rst_n)
            if (!rst_n) begin
                integ <= '0;
                dly   <= '0;
            end else if (clear) begin
                integ <= '0;
                dly   <= '0;
            end else begin
                if (strobe) integ <= integ_nxt;
                if (go) dly <= comb_in;
            end
    end

    // window counter; the last strobe of a window latches the final integrator and fires the combs next cycle
    always_ff @(posedge clk_board or negedge rst_n)
        if (!rst_n) begin
            decim_cnt <= '0;
            latched   <= '0;
            go        <= 1'b0;
        end else if (clear) begin
            decim_cnt <= '0;
            latched   <= '0;
            go        <= 1'b0;
        end else begin
            go <= strobe && &decim_cnt;
            if (strobe) decim_cnt <= decim_cnt + 1'b1;
            if (strobe && &decim_cnt) latched <= stg[ORDER-1].integ_nxt;
        end

    assign y             = stg[ORDER-1].comb_out;
    assign result        = y[CIC_W-1 -: OUT_WIDTH];
    assign result_strobe = go;

    if (OUT_WIDTH < CIC_W) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^y[CIC_W-OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/mic_pdm_rx.sv
// mic_pdm_rx: PDM mic receiver - bit clock generation, bit capture, CIC decimation, PCM stream output
module mic_pdm_rx
    import mic_pkg::*;
#(
    parameter int DIV_FACTOR  = 10,
    parameter int DECIM       = 64,
    parameter int ORDER       = 3,
    parameter int OUT_WIDTH   = 16,
    parameter int SAMPLE_EDGE = 0
) (
    input  logic                 clk_board,
    input  logic                 rst_n,
    input  logic                 en,
    output logic                 pdm_clk,
    input  logic                 pdm_data,
    output logic [OUT_WIDTH-1:0] pcm_data,
    output logic                 pcm_valid,
    input  logic                 pcm_ready,
    output logic                 overflow
);

    localparam edge_sel_e EDGE = (SAMPLE_EDGE != 0) ? EDGE_FALL : EDGE_RISE;
    localparam int CW = $clog2(DIV_FACTOR);
    localparam int WW = $clog2(ORDER + 1);

    logic                 en_s1, en_sync, en_prev, d_s1, d_sync;
    logic                 cnt_done, strobe, res_stb, accept, blocked;
    logic [CW-1:0]        div_cnt;
    logic [WW-1:0]        warm;
    logic [OUT_WIDTH-1:0] res;

    // two-flop synchronisers for en and pdm_data, plus en history for rise detection
    always_ff @(posedge clk_board or negedge rst_n)
        if (!rst_n) {en_s1, en_sync, en_prev, d_s1, d_sync} <= '0;
        else {en_s1, en_sync, en_prev, d_s1, d_sync} <= {en, en_s1, en_sync, pdm_data, d_s1};

    assign cnt_done = div_cnt == CW'(DIV_FACTOR - 1);
    assign strobe   = en_sync && cnt_done && (pdm_clk == (EDGE == EDGE_RISE));

    // bit-clock divider: pdm_clk toggles every DIV_FACTOR cycles, parked low while disabled
    always_ff @(posedge clk_board or negedge rst_n)
        if (!rst_n) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
        end else if (!en_sync) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
        end else begin
            div_cnt <= cnt_done ? '0 : div_cnt + 1'b1;
            pdm_clk <= pdm_clk ^ cnt_done;
        end

    mic_cic_decim #(
        .DECIM    (DECIM),
        .ORDER    (ORDER),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_cic (
        .clk_board    (clk_board),
        .rst_n        (rst_n),
        .clear        (!en_sync),
        .strobe       (strobe),
        .bit_in       (d_sync),
        .result       (res),
        .result_strobe(res_stb)
    );

    assign accept  = en_sync && res_stb && warm == WW'(ORDER);
    assign blocked = pcm_valid && !pcm_ready;

    // warm-up discard, output holding register and sticky overflow
    always_ff @(posedge clk_board or negedge rst_n)
        if (!rst_n) begin
            warm      <= '0;
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (en_sync && !en_prev) overflow <= 1'b0;
            else if (accept && blocked) overflow <= 1'b1;
            if (!en_sync) begin
                warm      <= '0;
                pcm_data  <= '0;
                pcm_valid <= 1'b0;
            end else begin
                if (res_stb && warm != WW'(ORDER)) warm <= warm + 1'b1;
                if (accept && !blocked) begin
                    pcm_data  <= res;
                    pcm_valid <= 1'b1;
                end else if (pcm_valid && pcm_ready) begin
                    pcm_valid <= 1'b0;
                end
            end
        end

endmodule
